// File: rtl/alu_pkg.sv
// Shared ALU control encoding and the legality check used by the ALU arbiter.
package alu_pkg;

  localparam int ALU_CTRL_W = 4;

  localparam logic [ALU_CTRL_W-1:0] ALU_ADD = 4'b0010;
  localparam logic [ALU_CTRL_W-1:0] ALU_SUB = 4'b0110;
  localparam logic [ALU_CTRL_W-1:0] ALU_AND = 4'b0000;
  localparam logic [ALU_CTRL_W-1:0] ALU_OR  = 4'b0001;

  function automatic logic is_legal_alu_op(input logic [ALU_CTRL_W-1:0] op);
    return (op == ALU_ADD) || (op == ALU_SUB) || (op == ALU_AND) || (op == ALU_OR);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// N-input round-robin arbiter: one grant per cycle, search starts at the pointer,
// pointer moves past the winner and holds when nothing is granted.
module rr_arbiter #(
  parameter int N = 2,
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_vld
);

  logic [IDX_W-1:0] ptr;

  always_comb begin
    int idx;
    grant     = '0;
    grant_idx = '0;
    grant_vld = 1'b0;
    idx       = 0;
    for (int i = 0; i < N; i++) begin
      idx = int'(ptr) + i;
      if (idx >= N) idx = idx - N;
      if (!grant_vld && req[idx]) begin
        grant[idx] = 1'b1;
        grant_idx  = IDX_W'(idx);
        grant_vld  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (grant_vld) begin
      if (int'(grant_idx) == N - 1) ptr <= '0;
      else                          ptr <= grant_idx + 1'b1;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between N_REQ requesters; each requester gets a
// one-deep registered response slot and a saturating grant counter.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int N_REQ  = 2,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [N_REQ-1:0]          req_valid_i,
  output logic [N_REQ-1:0]          req_ready_o,
  input  logic [ALU_CTRL_W*N_REQ-1:0] req_op_i,
  input  logic [DATA_W*N_REQ-1:0]   req_a_i,
  input  logic [DATA_W*N_REQ-1:0]   req_b_i,
  output logic [N_REQ-1:0]          resp_valid_o,
  input  logic [N_REQ-1:0]          resp_ready_i,
  output logic [DATA_W*N_REQ-1:0]   resp_data_o,
  output logic [N_REQ-1:0]          resp_err_o,
  output logic [DATA_W-1:0]         alu_data1_o,
  output logic [DATA_W-1:0]         alu_data2_o,
  output logic [ALU_CTRL_W-1:0]     alu_ctrl_o,
  input  logic [DATA_W-1:0]         alu_result_i,
  output logic [CNT_W*N_REQ-1:0]    grant_cnt_o
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [N_REQ-1:0] eligible;
  logic [N_REQ-1:0] grant;
  logic [IDX_W-1:0] grant_idx;
  logic             grant_vld;
  logic             op_legal;

  // A full slot may be refilled in the same cycle it is drained.
  always_comb begin
    eligible = req_valid_i & (~resp_valid_o | resp_ready_i) & {N_REQ{~rst_i}};
  end

  rr_arbiter #(.N(N_REQ)) u_rr (
    .clk       (clk_i),
    .rst       (rst_i),
    .req       (eligible),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_vld (grant_vld)
  );

  assign req_ready_o = grant;

  always_comb begin
    alu_data1_o = '0;
    alu_data2_o = '0;
    alu_ctrl_o  = '0;
    if (grant_vld) begin
      alu_data1_o = req_a_i[int'(grant_idx)*DATA_W +: DATA_W];
      alu_data2_o = req_b_i[int'(grant_idx)*DATA_W +: DATA_W];
      alu_ctrl_o  = req_op_i[int'(grant_idx)*ALU_CTRL_W +: ALU_CTRL_W];
    end
  end

  assign op_legal = is_legal_alu_op(alu_ctrl_o);

  // ---- capture stage: ALU result into the granted slot ----
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      resp_valid_o <= '0;
      resp_err_o   <= '0;
      resp_data_o  <= '0;
      grant_cnt_o  <= '0;
    end else begin
      for (int k = 0; k < N_REQ; k++) begin
        if (grant[k]) begin
          resp_valid_o[k] <= 1'b1;
          resp_err_o[k]   <= ~op_legal;
          resp_data_o[k*DATA_W +: DATA_W] <= op_legal ? alu_result_i : '0;
          if (grant_cnt_o[k*CNT_W +: CNT_W] != CNT_MAX)
            grant_cnt_o[k*CNT_W +: CNT_W] <= grant_cnt_o[k*CNT_W +: CNT_W] + 1'b1;
        end else if (resp_ready_i[k]) begin
          resp_valid_o[k] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: reference arbiter/ALU model pushes expected
// responses, an independent monitor pops and compares them.
module tb_alu_arbiter;

  localparam int N  = 2;
  localparam int DW = 32;
  localparam int CW = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_ready;
  logic [4*N-1:0]  req_op = '0;
  logic [DW*N-1:0] req_a = '0;
  logic [DW*N-1:0] req_b = '0;
  logic [N-1:0]    resp_valid;
  logic [N-1:0]    resp_ready = '0;
  logic [DW*N-1:0] resp_data;
  logic [N-1:0]    resp_err;
  logic [DW-1:0]   alu_d1, alu_d2, alu_res;
  logic [3:0]      alu_ctrl;
  logic [CW*N-1:0] grant_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW:0] exp_q [N][$];
  int  ptr;
  int  cnt [N];
  bit  armed = 1'b0;

  always #5 clk = ~clk;

  alu_arbiter #(.N_REQ(N), .DATA_W(DW), .CNT_W(CW)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_op_i     (req_op),
    .req_a_i      (req_a),
    .req_b_i      (req_b),
    .resp_valid_o (resp_valid),
    .resp_ready_i (resp_ready),
    .resp_data_o  (resp_data),
    .resp_err_o   (resp_err),
    .alu_data1_o  (alu_d1),
    .alu_data2_o  (alu_d2),
    .alu_ctrl_o   (alu_ctrl),
    .alu_result_i (alu_res),
    .grant_cnt_o  (grant_cnt)
  );

  // External ALU; illegal codes return a marker that must never reach a slot.
  always_comb begin
    case (alu_ctrl)
      4'b0010: alu_res = alu_d1 + alu_d2;
      4'b0110: alu_res = alu_d1 - alu_d2;
      4'b0000: alu_res = alu_d1 & alu_d2;
      4'b0001: alu_res = alu_d1 | alu_d2;
      default: alu_res = 32'hDEAD_BEEF;
    endcase
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected {err, data} for an accepted operation.
  function automatic logic [DW:0] ref_resp(input logic [3:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
    longint unsigned sum;
    case (op)
      4'b0010: begin sum = longint'(a) + longint'(b); return {1'b0, sum[DW-1:0]}; end
      4'b0110: begin sum = (longint'(1) << DW) + longint'(a) - longint'(b); return {1'b0, sum[DW-1:0]}; end
      4'b0000: return {1'b0, a & b};
      4'b0001: return {1'b0, a | b};
      default: return {1'b1, {DW{1'b0}}};
    endcase
  endfunction

  // Reference model step, late in each cycle after the monitor has retired consumed responses.
  task automatic model_step();
    int g;
    logic [N-1:0] exp_rdy;
    logic [3:0] op;
    logic [DW-1:0] a, b;
    if (rst) begin
      check("ready_in_reset", req_ready, '0);
      for (int k = 0; k < N; k++) begin
        exp_q[k].delete();
        cnt[k] = 0;
      end
      ptr   = 0;
      armed = 1'b1;
      return;
    end
    if (!armed) return;
    g = -1;
    exp_rdy = '0;
    for (int i = 0; i < N; i++) begin
      int idx;
      idx = (ptr + i) % N;
      if (g < 0 && req_valid[idx] && exp_q[idx].size() == 0) g = idx;
    end
    if (g >= 0) exp_rdy[g] = 1'b1;
    check("req_ready", req_ready, exp_rdy);
    for (int k = 0; k < N; k++)
      check($sformatf("grant_cnt%0d", k), grant_cnt[k*CW +: CW], cnt[k]);
    if (g >= 0) begin
      op = req_op[g*4 +: 4];
      a  = req_a[g*DW +: DW];
      b  = req_b[g*DW +: DW];
      check("alu_drive", {alu_ctrl, alu_d1, alu_d2}, {op, a, b});
      exp_q[g].push_back(ref_resp(op, a, b));
      if (cnt[g] < (1 << CW) - 1) cnt[g]++;
      ptr = (g + 1) % N;
    end else begin
      check("alu_idle", {alu_ctrl, alu_d1, alu_d2}, '0);
    end
  endtask

  always @(negedge clk) begin
    #1;
    model_step();
  end

  // Monitor: compares slot contents against the scoreboard and retires on consume.
  always @(negedge clk) begin
    logic [DW:0] e;
    if (armed) begin
      for (int k = 0; k < N; k++) begin
        check($sformatf("resp_valid%0d", k), resp_valid[k], exp_q[k].size() != 0);
        if (exp_q[k].size() != 0) begin
          e = exp_q[k][0];
          check($sformatf("resp_data%0d", k), resp_data[k*DW +: DW], e[DW-1:0]);
          check($sformatf("resp_err%0d", k), resp_err[k], e[DW]);
          if (resp_ready[k]) e = exp_q[k].pop_front();
        end
      end
    end
  end

  task automatic drive(input logic r, input logic [N-1:0] v, input logic [N-1:0] rr,
                       input logic [3:0] o0, input logic [DW-1:0] a0, input logic [DW-1:0] b0,
                       input logic [3:0] o1, input logic [DW-1:0] a1, input logic [DW-1:0] b1);
    @(posedge clk);
    #1;
    rst        = r;
    req_valid  = v;
    resp_ready = rr;
    req_op     = {o1, o0};
    req_a      = {a1, a0};
    req_b      = {b1, b0};
  endtask

  task automatic do_reset();
    drive(1'b1, 2'b11, 2'b00, 4'b0010, 1, 1, 4'b0010, 2, 2);
    drive(1'b0, 2'b00, 2'b00, 4'b0000, 0, 0, 4'b0000, 0, 0);
  endtask

  function automatic logic [3:0] rand_op();
    logic [3:0] ops [4];
    ops[0] = 4'b0010; ops[1] = 4'b0110; ops[2] = 4'b0000; ops[3] = 4'b0001;
    if ($urandom_range(0, 7) == 0) return 4'($urandom);
    return ops[$urandom_range(0, 3)];
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    do_reset();

    // Single add from requester 0
    drive(1'b0, 2'b01, 2'b00, 4'b0010, 5, 7, 4'b0000, 0, 0);
    #3;
    check("t1_ready", req_ready, 2'b01);
    check("t1_ctrl", alu_ctrl, 4'b0010);
    drive(1'b0, 2'b00, 2'b01, 4'b0000, 0, 0, 4'b0000, 0, 0);
    #3;
    check("t1_valid", resp_valid[0], 1'b1);
    check("t1_data", resp_data[31:0], 32'd12);
    check("t1_err", resp_err[0], 1'b0);

    // Both requesting, always drained: strict alternation from 0
    do_reset();
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 2'b11, 2'b11, 4'b0010, i, 1, 4'b0110, 3, 5);
      #3;
      check("t2_alternate", req_ready, (i % 2 == 0) ? 2'b01 : 2'b10);
      if (i == 2) check("t2_sub_wrap", resp_data[63:32], 32'hFFFF_FFFE);
    end

    // Held slot blocks its requester; drain-and-refill keeps valid high
    do_reset();
    drive(1'b0, 2'b11, 2'b00, 4'b0010, 1, 1, 4'b0001, 8, 1);
    drive(1'b0, 2'b11, 2'b00, 4'b0010, 1, 1, 4'b0001, 8, 1);
    #3;
    check("t3_full_skip", req_ready, 2'b10);
    drive(1'b0, 2'b11, 2'b10, 4'b0010, 1, 1, 4'b0001, 16, 1);
    #3;
    check("t3_r1_refill", req_ready, 2'b10);
    drive(1'b0, 2'b11, 2'b01, 4'b0010, 100, 200, 4'b0001, 32, 1);
    #3;
    check("t3_r0_refill", req_ready, 2'b01);
    check("t3_old_data", resp_data[31:0], 32'd2);
    drive(1'b0, 2'b00, 2'b11, 4'b0000, 0, 0, 4'b0000, 0, 0);
    #3;
    check("t3_valid_kept", resp_valid[0], 1'b1);
    check("t3_new_data", resp_data[31:0], 32'd300);

    // Illegal op then a legal AND
    do_reset();
    drive(1'b0, 2'b10, 2'b00, 4'b0000, 0, 0, 4'b1111, 123, 456);
    #3;
    check("t4_ill_ready", req_ready, 2'b10);
    drive(1'b0, 2'b10, 2'b10, 4'b0000, 0, 0, 4'b0000, 32'hF0F0, 32'h0FF0);
    #3;
    check("t4_ill_data", resp_data[63:32], 32'h0);
    check("t4_ill_err", resp_err[1], 1'b1);
    drive(1'b0, 2'b00, 2'b10, 4'b0000, 0, 0, 4'b0000, 0, 0);
    #3;
    check("t4_and_data", resp_data[63:32], 32'h0000_00F0);
    check("t4_and_err", resp_err[1], 1'b0);

    // Reset with a full slot
    do_reset();
    drive(1'b0, 2'b01, 2'b00, 4'b0010, 1, 2, 4'b0000, 0, 0);
    drive(1'b1, 2'b11, 2'b00, 4'b0010, 1, 2, 4'b0010, 3, 4);
    #3;
    check("t5_rst_ready", req_ready, 2'b00);
    drive(1'b0, 2'b11, 2'b00, 4'b0010, 1, 2, 4'b0010, 3, 4);
    #3;
    check("t5_valid_clr", resp_valid, 2'b00);
    check("t5_cnt_clr", grant_cnt, '0);
    check("t5_first_r0", req_ready, 2'b01);

    // Counter saturation
    do_reset();
    for (int i = 0; i < 20; i++)
      drive(1'b0, 2'b01, 2'b01, 4'b0010, i, i, 4'b0000, 0, 0);
    drive(1'b0, 2'b00, 2'b11, 4'b0000, 0, 0, 4'b0000, 0, 0);
    #3;
    check("t6_sat", grant_cnt[3:0], 4'd15);
    check("t6_other", grant_cnt[7:4], 4'd0);

    // Randomized traffic
    for (int i = 0; i < 2000; i++) begin
      drive($urandom_range(0, 99) == 0, 2'($urandom), 2'($urandom),
            rand_op(), $urandom, $urandom, rand_op(), $urandom, $urandom);
    end
    for (int i = 0; i < 3; i++)
      drive(1'b0, 2'b00, 2'b11, 4'b0000, 0, 0, 4'b0000, 0, 0);
    @(posedge clk);
    #6;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
Round-robin arbiter and sequencer that shares one combinational ALU (32-bit data, 4-bit ALUCtrl encoding) between N_REQ requesters (default 2, e.g. execute stage and address/branch helper).
- Each requester issues one operation through a valid/ready request handshake.
- Each request receives a registered result through its own one-deep response slot with a valid/ready handshake.
- The block drives the ALU's operand and control inputs and captures its result.

Parameters:
N_REQ, 2, number of requesters (2..4)
DATA_W, 32, operand/result width; must match the ALU
CNT_W, 16, width of per-requester saturating grant counters

Ports:
clk_i  input  1  clock, all state updates on rising edge
rst_i  input  1  synchronous active-high reset
req_valid_i  input  N_REQ  request valid, one bit per requester
req_ready_o  output  N_REQ  request accepted this cycle (equals grant)
req_op_i  input  4*N_REQ  ALUCtrl code per requester, requester k in bits [4k+3:4k]
req_a_i  input  DATA_W*N_REQ  operand 1 per requester
req_b_i  input  DATA_W*N_REQ  operand 2 per requester
resp_valid_o  output  N_REQ  response slot k holds a result
resp_ready_i  input  N_REQ  requester k consumes its response
resp_data_o  output  DATA_W*N_REQ  registered result per requester
resp_err_o  output  N_REQ  slot k result came from an illegal op
alu_data1_o  output  DATA_W  to ALU data1_i
alu_data2_o  output  DATA_W  to ALU data2_i
alu_ctrl_o  output  4  to ALU ALUCtrl_i
alu_result_i  input  DATA_W  from ALU data_o
grant_cnt_o  output  CNT_W*N_REQ  saturating count of accepted requests per requester

Behaviour:
- Reset: one clock, synchronous, active-high (clk_i / rst_i). While rst_i is high at a clock edge:
  - resp_valid_o, resp_err_o, resp_data_o and grant_cnt_o clear to 0.
  - The priority pointer is set so requester 0 has highest priority.
  - A request presented during a reset cycle is not accepted and produces no response. Any in-flight slot content is discarded.
- Eligibility: requester k is eligible when req_valid_i[k]=1 and either resp_valid_o[k]=0, or resp_valid_o[k]=1 with resp_ready_i[k]=1 in the same cycle (drain-and-refill).
- Arbitration:
  - At most one grant per cycle.
  - Round-robin over eligible requesters, starting from the priority pointer.
  - The pointer moves to (granted index + 1) mod N_REQ after a grant and is unchanged when there is no grant.
  - req_ready_o is combinational from req_valid_i, the slot state and the pointer. req_valid_i must not depend on req_ready_o.
- ALU drive:
  - With a grant: alu_data1_o, alu_data2_o and alu_ctrl_o carry the granted requester's operands and op, combinationally in the same cycle.
  - With no grant: all three drive 0.
- Capture and latency:
  - At the edge ending a grant cycle, alu_result_i is written into slot k and resp_valid_o[k] is set.
  - The response is visible exactly 1 cycle after acceptance.
- Legal ops: 0010 add, 0110 sub, 0000 and, 0001 or.
  - Add and sub wrap modulo 2^DATA_W. No carry or overflow output.
  - An accepted illegal op still gets a response: resp_data_o[k]=0 and resp_err_o[k]=1. The ALU result is ignored for that op.
- Slot clear: resp_valid_o[k] drops at the edge where resp_ready_i[k]=1, unless slot k is refilled in that same cycle. On refill it stays 1 with the new data. resp_data_o holds its value while valid and not consumed.
- Counters: grant_cnt_o[k] increments on each accepted request from k and saturates at 2^CNT_W-1.
- Fairness: a requester that keeps req_valid_i high and drains its responses is granted within N_REQ cycles.
- All slots full and undrained: no grant, req_ready_o all 0, ALU inputs 0.

Decomposition:
Shared package alu_pkg holds:
- ALU control constants: ALU_ADD=4'b0010, ALU_SUB=4'b0110, ALU_AND=4'b0000, ALU_OR=4'b0001.
- ALU_CTRL_W=4.
- An is_legal_alu_op function.

One sub-module, rr_arbiter (N-input round-robin grant with pointer update), is natural. The response slots and counters stay in alu_arbiter.

Test Plan:
1. Reset then single request: r0 add a=5, b=7 → req_ready_o[0]=1 same cycle, alu_ctrl_o=0010, next cycle resp_valid_o[0]=1, resp_data_o[0]=12, resp_err_o[0]=0.
2. Both requesters valid every cycle, responses always drained → grants alternate 0,1,0,1 starting with 0. r1 sub 3-5 returns 0xFFFFFFFE.
3. r0 response held (resp_ready_i[0]=0) with r0 still requesting → r0 not granted while full, r1 granted. Raising resp_ready_i[0] for one cycle with r0 valid → drain-and-refill the same cycle, resp_valid_o[0] stays 1 with the new result.
4. Illegal op 4'b1111 from r1 → accepted, resp_data_o[1]=0, resp_err_o[1]=1. A following legal and 0xF0F0 & 0x0FF0 → 0x00F0 with err=0.
5. rst_i asserted the cycle after a grant with the slot full → next cycle all resp_valid_o=0, grant_cnt_o=0, and the first post-reset grant goes to r0 when both request.
6. CNT_W=4, 20 r0 grants → grant_cnt_o[0]=15 (saturated), grant_cnt_o[1] unchanged.
